md_unit: RTL



---
 rtl/md_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the E stage: computes the 64-bit result at start,
// holds it pending for a fixed busy window, then commits it to HI/LO.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    // Returns {HI, LO}. A zero divisor is replaced by 1 only to keep the
    // arithmetic defined; that result is never committed.
    function automatic logic [63:0] md_calc(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sp;
        logic        [63:0] up;
        logic signed [32:0] sa, sb, sq, sr;
        logic        [31:0] ub, uq, ur;
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up = {32'd0, a} * {32'd0, b};
        // 33-bit signed operands make 0x80000000 / -1 yield 2^31, truncating to 0x80000000
        sa = {a[31], a};
        sb = (b == 32'd0) ? 33'sd1 : {b[31], b};
        sq = sa / sb;
        sr = sa % sb;
        ub = (b == 32'd0) ? 32'd1 : b;
        uq = a / ub;
        ur = a % ub;
        case (op)
            4'd1:    md_calc = sp;
            4'd2:    md_calc = up;
            4'd3:    md_calc = {32'(sr), 32'(sq)};
            4'd4:    md_calc = {ur, uq};
            default: md_calc = 64'd0;
        endcase
    endfunction

    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [63:0]      pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             dz_q, dz_d;
    logic             accept, is_div;

    always_comb begin
        accept = start && !busy_q && (md_op >= 4'd1) && (md_op <= 4'd4);
        is_div = (md_op == 4'd3) || (md_op == 4'd4);
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        dz_d   = dz_q;
        if (accept) begin
            cnt_d  = is_div ? DIV_N : MULT_N;
            pend_d = md_calc(md_op, A, B);
            dz_d   = is_div && (B == 32'd0);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && !dz_q) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end else if (!start) begin
            if (md_op == 4'd7) hi_d = A;
            if (md_op == 4'd8) lo_d = A;
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            dz_q   <= dz_d;
        end
    end

    always_comb begin
        out = 32'd0;
        if (md_op == 4'd5) out = hi_q;
        if (md_op == 4'd6) out = lo_q;
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
